lfsr_checker: RTL and testbench

Receive-side companion to the `lfsr` generator. It self-synchronises to a 32-bit pseudo-random word stream. It uses its own predictor to check every subsequent word and reports lock status, per-word error pulses, and saturating word- and bit-error counts. It sits at the far end of a link or loopback path driven by `lfsr`, and is used for link BER testing and for checking the generator itself.

---
 rtl/lfsr_pkg.sv | 23 ++
 rtl/popcount32.sv | 15 +
 rtl/lfsr_checker.sv | 132 +++++++++++++
 tb/tb_lfsr_checker.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 32-bit LFSR generator/checker pair.
// Both ends step with lfsr_next so the polynomial lives in one place.
package lfsr_pkg;

    localparam int LFSR_W = 32;

    // x^32 + x^22 + x^2 + x^1 + 1, expressed as bit positions of the shift register
    localparam int TAP_A = 31;
    localparam int TAP_B = 21;
    localparam int TAP_C = 1;
    localparam int TAP_D = 0;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } chk_state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
    endfunction

endpackage

// File: rtl/popcount32.sv
// Counts set bits of a 32-bit vector; purely combinational, no flow control.
// Kept standalone so a pipelined variant can drop in later.
module popcount32 (
    input  logic [31:0] vec_i,
    output logic [5:0]  cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < 32; i++) begin
            cnt_o = cnt_o + {5'd0, vec_i[i]};
        end
    end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS checker: hunts, verifies, then flywheels on a predictor.
// All outputs registered, one cycle after the sampling edge; never stalls (en_i gates progress).
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [31:0] random_i,
    input  logic        clr_cnt_i,
    output logic        locked_o,
    output logic        err_o,
    output logic [15:0] err_cnt_o,
    output logic [31:0] bit_err_cnt_o,
    output logic [31:0] expected_o
);

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_TGT = 4'(LOSS_CNT);

    chk_state_t  state_q, state_d;
    logic [31:0] pred_q, pred_d;
    logic [3:0]  match_q, match_d;
    logic [3:0]  miss_q, miss_d;
    logic        err_q, err_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [31:0] bit_cnt_q, bit_cnt_d;

    logic [5:0]  pop;
    logic        mismatch;
    logic [32:0] bit_sum;

    popcount32 u_popcount (
        .vec_i (random_i ^ pred_q),
        .cnt_o (pop)
    );

    assign mismatch = (random_i != pred_q);
    // One spare bit catches the carry so the bit counter saturates instead of wrapping
    assign bit_sum  = {1'b0, bit_cnt_q} + {27'd0, pop};

    always_comb begin
        state_d   = state_q;
        pred_d    = pred_q;
        match_d   = match_q;
        miss_d    = miss_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        bit_cnt_d = bit_cnt_q;

        if (en_i) begin
            case (state_q)
                HUNT: begin
                    // An all-zero word is the LFSR lock-up state and can never seed a valid stream
                    if (random_i != '0) begin
                        pred_d  = lfsr_next(random_i);
                        match_d = '0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (!mismatch) begin
                        match_d = match_q + 4'd1;
                        pred_d  = lfsr_next(pred_q);
                        if (match_q + 4'd1 == LOCK_TGT) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else if (random_i == '0) begin
                        state_d = HUNT;
                        match_d = '0;
                        pred_d  = '0;
                    end else begin
                        pred_d  = lfsr_next(random_i);
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    pred_d = lfsr_next(pred_q);
                    if (mismatch) begin
                        err_d     = 1'b1;
                        err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
                        bit_cnt_d = bit_sum[32] ? 32'hFFFF_FFFF : bit_sum[31:0];
                        miss_d    = miss_q + 4'd1;
                        if (miss_q + 4'd1 == LOSS_TGT) begin
                            state_d = HUNT;
                            match_d = '0;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (clr_cnt_i) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= HUNT;
            pred_q    <= '0;
            match_q   <= '0;
            miss_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pred_q    <= pred_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign locked_o      = (state_q == LOCKED);
    assign err_o         = err_q;
    assign err_cnt_o     = err_cnt_q;
    assign bit_err_cnt_o = bit_cnt_q;
    assign expected_o    = (state_q == HUNT) ? 32'd0 : pred_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: vector table for lock/error/loss, hand sequences for corners.
// A second instance with LOSS_CNT=15 runs in parallel to drive the word counter into saturation.
module tb_lfsr_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, clr;
    logic [31:0] rnd;
    logic        locked, err;
    logic [15:0] err_cnt;
    logic [31:0] bit_cnt, expd;

    logic        b_rst, b_en, b_clr;
    logic [31:0] b_rnd;
    logic        b_locked, b_err;
    logic [15:0] b_err_cnt;
    logic [31:0] b_bit_cnt, b_expd;

    lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(3)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .random_i(rnd), .clr_cnt_i(clr),
        .locked_o(locked), .err_o(err), .err_cnt_o(err_cnt),
        .bit_err_cnt_o(bit_cnt), .expected_o(expd)
    );

    lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(15)) dut_sat (
        .clk_i(clk), .rst_i(b_rst), .en_i(b_en), .random_i(b_rnd), .clr_cnt_i(b_clr),
        .locked_o(b_locked), .err_o(b_err), .err_cnt_o(b_err_cnt),
        .bit_err_cnt_o(b_bit_cnt), .expected_o(b_expd)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] g;
    logic [31:0] g2;

    function automatic logic [31:0] ref_step(input logic [31:0] s);
        logic fb;
        fb = s[31] ^ s[21] ^ s[1] ^ s[0];
        return {s[30:0], fb};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic a_step(input logic e, input logic [31:0] m, input logic c);
        en  = e;
        rnd = g ^ m;
        clr = c;
        @(posedge clk);
        if (e) g = ref_step(g);
        #1;
    endtask

    task automatic b_step(input logic e, input logic [31:0] m, input logic c);
        b_en  = e;
        b_rnd = g2 ^ m;
        b_clr = c;
        @(posedge clk);
        if (e) g2 = ref_step(g2);
        #1;
    endtask

    task automatic a_reset();
        rst = 1'b1; en = 1'b0; clr = 1'b0; rnd = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic a_check_reset(input string tag);
        check({tag, " locked"},   {31'd0, locked}, 32'd0);
        check({tag, " err"},      {31'd0, err},    32'd0);
        check({tag, " err_cnt"},  {16'd0, err_cnt}, 32'd0);
        check({tag, " bit_cnt"},  bit_cnt, 32'd0);
        check({tag, " expected"}, expd,    32'd0);
    endtask

    typedef struct packed {
        logic        en;
        logic [31:0] mask;
        logic        clr;
        logic        x_locked;
        logic        x_err;
        logic [15:0] x_cnt;
        logic [31:0] x_bits;
        logic        x_pred;
    } vec_t;

    function automatic vec_t mk(input logic e, input logic [31:0] m, input logic c,
                                input logic l, input logic er, input logic [15:0] cn,
                                input logic [31:0] bi, input logic p);
        vec_t v;
        v = '{en: e, mask: m, clr: c, x_locked: l, x_err: er, x_cnt: cn, x_bits: bi, x_pred: p};
        return v;
    endfunction

    vec_t vt[19];

    task automatic run_main();
        int nvalid;
        int cyc;
        logic e;

        rst = 1'b0; en = 1'b0; clr = 1'b0; rnd = '0;
        a_reset();
        a_check_reset("reset");

        // All-zero words in HUNT must be ignored
        for (int i = 0; i < 3; i++) begin
            en = 1'b1; rnd = '0; clr = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("zero[%0d] locked", i),   {31'd0, locked}, 32'd0);
            check($sformatf("zero[%0d] expected", i), expd, 32'd0);
            check($sformatf("zero[%0d] err", i),      {31'd0, err}, 32'd0);
        end

        //        en    mask           clr   lock  err  cnt     bits   pred
        vt[0]  = mk(1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 16'd0, 32'd0,  1'b1);
        vt[1]  = mk(1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 16'd0, 32'd0,  1'b1);
        vt[2]  = mk(1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 16'd0, 32'd0,  1'b1);
        vt[3]  = mk(1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 16'd0, 32'd0,  1'b1);
        vt[4]  = mk(1'b1, 32'h0,        1'b0, 1'b1, 1'b0, 16'd0, 32'd0,  1'b1);
        vt[5]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 16'd0, 32'd0,  1'b1);
        vt[6]  = mk(1'b1, 32'h0,        1'b0, 1'b1, 1'b0, 16'd0, 32'd0,  1'b1);
        vt[7]  = mk(1'b1, 32'h1,        1'b0, 1'b1, 1'b1, 16'd1, 32'd1,  1'b1);
        vt[8]  = mk(1'b1, 32'h0,        1'b0, 1'b1, 1'b0, 16'd1, 32'd1,  1'b1);
        vt[9]  = mk(1'b1, 32'h0,        1'b1, 1'b1, 1'b0, 16'd0, 32'd0,  1'b1);
        vt[10] = mk(1'b1, 32'hFFFF0000, 1'b0, 1'b1, 1'b1, 16'd1, 32'd16, 1'b1);
        vt[11] = mk(1'b1, 32'hFFFF0000, 1'b0, 1'b1, 1'b1, 16'd2, 32'd32, 1'b1);
        vt[12] = mk(1'b1, 32'hFFFF0000, 1'b0, 1'b0, 1'b1, 16'd3, 32'd48, 1'b0);
        vt[13] = mk(1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 16'd3, 32'd48, 1'b1);
        vt[14] = mk(1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 16'd3, 32'd48, 1'b1);
        vt[15] = mk(1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 16'd3, 32'd48, 1'b1);
        vt[16] = mk(1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 16'd3, 32'd48, 1'b1);
        vt[17] = mk(1'b1, 32'h0,        1'b0, 1'b1, 1'b0, 16'd3, 32'd48, 1'b1);
        vt[18] = mk(1'b1, 32'h0,        1'b0, 1'b1, 1'b0, 16'd3, 32'd48, 1'b1);

        g = 32'h974CA351;
        for (int i = 0; i < 19; i++) begin
            a_step(vt[i].en, vt[i].mask, vt[i].clr);
            check($sformatf("vec[%0d] locked", i),   {31'd0, locked}, {31'd0, vt[i].x_locked});
            check($sformatf("vec[%0d] err", i),      {31'd0, err},    {31'd0, vt[i].x_err});
            check($sformatf("vec[%0d] err_cnt", i),  {16'd0, err_cnt}, {16'd0, vt[i].x_cnt});
            check($sformatf("vec[%0d] bit_cnt", i),  bit_cnt, vt[i].x_bits);
            check($sformatf("vec[%0d] expected", i), expd, vt[i].x_pred ? g : 32'd0);
        end

        // Reset while locked with a valid word present
        rst = 1'b1; en = 1'b1; rnd = g; clr = 1'b0;
        @(posedge clk);
        g = ref_step(g);
        #1;
        rst = 1'b0;
        a_check_reset("midrst");
        for (int k = 0; k < 5; k++) begin
            a_step(1'b1, 32'h0, 1'b0);
            check($sformatf("relock[%0d] locked", k), {31'd0, locked}, {31'd0, (k == 4)});
        end
        check("relock err_cnt", {16'd0, err_cnt}, 32'd0);

        // Second seed with random en gaps: lock on the 5th valid word, never an error
        a_reset();
        g = 32'h5829487A;
        nvalid = 0;
        cyc = 0;
        while (nvalid < 5 && cyc < 200) begin
            e = 1'($urandom_range(0, 1));
            a_step(e, 32'h0, 1'b0);
            if (e) nvalid++;
            cyc++;
            check($sformatf("gap[%0d] locked", cyc), {31'd0, locked}, {31'd0, (nvalid >= 5)});
        end
        for (int i = 0; i < 100; i++) begin
            a_step(1'($urandom_range(0, 1)), 32'h0, 1'b0);
        end
        check("gap locked",   {31'd0, locked}, 32'd1);
        check("gap err_cnt",  {16'd0, err_cnt}, 32'd0);
        check("gap bit_cnt",  bit_cnt, 32'd0);
        check("gap expected", expd, g);
    endtask

    task automatic run_sat();
        int nerr;
        int run;

        b_rst = 1'b1; b_en = 1'b0; b_clr = 1'b0; b_rnd = '0;
        @(posedge clk);
        #1;
        b_rst = 1'b0;
        g2 = 32'h974CA351;
        for (int i = 0; i < 5; i++) b_step(1'b1, 32'h0, 1'b0);
        check("sat lock", {31'd0, b_locked}, 32'd1);

        // 14 misses then one match keeps lock with LOSS_CNT=15
        nerr = 0;
        run = 0;
        while (nerr < 65536) begin
            if (run == 14) begin
                b_step(1'b1, 32'h0, 1'b0);
                run = 0;
            end else begin
                b_step(1'b1, 32'h1, 1'b0);
                nerr++;
                run++;
                if (nerr == 65534) check("sat cnt FFFE", {16'd0, b_err_cnt}, 32'h0000FFFE);
                if (nerr == 65535) check("sat cnt FFFF", {16'd0, b_err_cnt}, 32'h0000FFFF);
            end
        end
        check("sat cnt hold", {16'd0, b_err_cnt}, 32'h0000FFFF);
        check("sat bit_cnt",  b_bit_cnt, 32'h00010000);
        check("sat locked",   {31'd0, b_locked}, 32'd1);
        check("sat err",      {31'd0, b_err}, 32'd1);

        // Clear coincident with an error: error pulses but is not counted
        b_step(1'b1, 32'h1, 1'b1);
        check("clr err",     {31'd0, b_err}, 32'd1);
        check("clr err_cnt", {16'd0, b_err_cnt}, 32'd0);
        check("clr bit_cnt", b_bit_cnt, 32'd0);
        b_step(1'b1, 32'h1, 1'b0);
        check("post clr err_cnt", {16'd0, b_err_cnt}, 32'd1);
        check("post clr bit_cnt", b_bit_cnt, 32'd1);
    endtask

    initial begin
        fork
            run_main();
            run_sat();
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
